// File: rtl/rtc_pkg.sv
// Shared constants, FSM state type and BCD helpers for the RTC bus reader.
package rtc_pkg;

    localparam int unsigned TPH_DEFAULT  = 8;
    localparam int unsigned TGAP_DEFAULT = 4;
    localparam int unsigned NUM_REGS     = 9;

    localparam logic [7:0] CMD_LATCH     = 8'hF0;
    localparam logic [7:0] ADDR_SEGUNDO  = 8'h21;
    localparam logic [7:0] ADDR_MINUTO   = 8'h22;
    localparam logic [7:0] ADDR_HORA     = 8'h23;
    localparam logic [7:0] ADDR_DIA      = 8'h24;
    localparam logic [7:0] ADDR_MES      = 8'h25;
    localparam logic [7:0] ADDR_ANO      = 8'h26;
    localparam logic [7:0] ADDR_SEGUNDOT = 8'h41;
    localparam logic [7:0] ADDR_MINUTOT  = 8'h42;
    localparam logic [7:0] ADDR_HORAT    = 8'h43;

    // Shadow/output slot index follows the read order.
    localparam logic [3:0] IDX_SEGUNDO  = 4'd0;
    localparam logic [3:0] IDX_MINUTO   = 4'd1;
    localparam logic [3:0] IDX_HORA     = 4'd2;
    localparam logic [3:0] IDX_DIA      = 4'd3;
    localparam logic [3:0] IDX_MES      = 4'd4;
    localparam logic [3:0] IDX_ANO      = 4'd5;
    localparam logic [3:0] IDX_SEGUNDOT = 4'd6;
    localparam logic [3:0] IDX_MINUTOT  = 4'd7;
    localparam logic [3:0] IDX_HORAT    = 4'd8;
    localparam logic [3:0] IDX_LAST     = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        CMD_ADDR,
        CMD_DATA,
        RD_ADDR,
        RD_DATA,
        COMMIT
    } rtc_state_e;

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] addr;
        unique case (idx)
            IDX_SEGUNDO:  addr = ADDR_SEGUNDO;
            IDX_MINUTO:   addr = ADDR_MINUTO;
            IDX_HORA:     addr = ADDR_HORA;
            IDX_DIA:      addr = ADDR_DIA;
            IDX_MES:      addr = ADDR_MES;
            IDX_ANO:      addr = ADDR_ANO;
            IDX_SEGUNDOT: addr = ADDR_SEGUNDOT;
            IDX_MINUTOT:  addr = ADDR_MINUTOT;
            IDX_HORAT:    addr = ADDR_HORAT;
            default:      addr = 8'h00;
        endcase
        return addr;
    endfunction

    // Non-decimal nibbles become 4'hF so the display shows a blank digit.
    function automatic logic [7:0] bcd_blank(input logic [7:0] v);
        logic [7:0] r;
        r[7:4] = (v[7:4] > 4'd9) ? 4'hF : v[7:4];
        r[3:0] = (v[3:0] > 4'd9) ? 4'hF : v[3:0];
        return r;
    endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// Phase timer: TPH strobe-low cycles followed by TGAP idle cycles while go is held.
module rtc_bus_phase #(
    parameter int unsigned TPH  = 8,
    parameter int unsigned TGAP = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic go,
    output logic strobe_low,
    output logic sample_en,
    output logic phase_done
);

    localparam int unsigned PERIOD = TPH + TGAP;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        strobe_low = go && (cnt_q < CNT_W'(TPH));
        sample_en  = go && (cnt_q == CNT_W'(TPH - 1));
        phase_done = go && (cnt_q == CNT_W'(PERIOD - 1));
        // Wrap on phase_done so back-to-back phases need no idle cycle.
        cnt_d = (!go || phase_done) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_bus_reader.sv
// Sweeps the RTC over its multiplexed bus and publishes an atomic packed-BCD snapshot
// of date, time and countdown timer, raising ALARMA when the committed timer reads zero.
module rtc_bus_reader
    import rtc_pkg::*;
#(
    parameter int unsigned TPH  = TPH_DEFAULT,
    parameter int unsigned TGAP = TGAP_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       TIMER_EN,
    input  logic       ALARM_ACK,
    input  logic [7:0] AD_IN,
    output logic [7:0] AD_OUT,
    output logic       AD_OE,
    output logic       CS_N,
    output logic       AD_N,
    output logic       WR_N,
    output logic       RD_N,
    output logic [7:0] DIA_T,
    output logic [7:0] MES_T,
    output logic [7:0] ANO_T,
    output logic [7:0] HORA_T,
    output logic [7:0] MINUTO_T,
    output logic [7:0] SEGUNDO_T,
    output logic [7:0] HORAT_T,
    output logic [7:0] MINUTOT_T,
    output logic [7:0] SEGUNDOT_T,
    output logic       ALARMA,
    output logic       BUSY,
    output logic       DONE
);

    rtc_state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] shadow_q [NUM_REGS];
    logic [7:0] out_q    [NUM_REGS];
    logic       done_q;
    logic       alarm_q, alarm_d;
    logic       commit;
    logic       phase_go;
    logic       strobe_low, sample_en, phase_done;

    // Kept apart from the FSM block: the timer outputs feed back into it.
    assign phase_go = (state_q == CMD_ADDR) || (state_q == CMD_DATA) ||
                      (state_q == RD_ADDR)  || (state_q == RD_DATA);

    rtc_bus_phase #(
        .TPH  (TPH),
        .TGAP (TGAP)
    ) u_phase (
        .CLK        (CLK),
        .RST        (RST),
        .go         (phase_go),
        .strobe_low (strobe_low),
        .sample_en  (sample_en),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        CS_N    = 1'b1;
        AD_N    = 1'b1;
        WR_N    = 1'b1;
        RD_N    = 1'b1;
        AD_OE   = 1'b0;
        AD_OUT  = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = CMD_ADDR;
                    idx_d   = 4'd0;
                end
            end
            CMD_ADDR: begin
                CS_N   = 1'b0;
                AD_OE  = 1'b1;
                AD_OUT = CMD_LATCH;
                AD_N   = !strobe_low;
                WR_N   = !strobe_low;
                if (phase_done) state_d = CMD_DATA;
            end
            CMD_DATA: begin
                CS_N   = 1'b0;
                AD_OE  = 1'b1;
                AD_OUT = CMD_LATCH;
                WR_N   = !strobe_low;
                if (phase_done) state_d = RD_ADDR;
            end
            RD_ADDR: begin
                CS_N   = 1'b0;
                AD_OE  = 1'b1;
                AD_OUT = reg_addr(idx_q);
                AD_N   = !strobe_low;
                WR_N   = !strobe_low;
                if (phase_done) state_d = RD_DATA;
            end
            RD_DATA: begin
                CS_N = 1'b0;
                RD_N = !strobe_low;
                if (phase_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = RD_ADDR;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh alarm outranks an acknowledge arriving in the same cycle.
    always_comb begin
        alarm_d = alarm_q;
        if (commit && TIMER_EN && (shadow_q[IDX_HORAT] == 8'h00) &&
            (shadow_q[IDX_MINUTOT] == 8'h00) && (shadow_q[IDX_SEGUNDOT] == 8'h00)) begin
            alarm_d = 1'b1;
        end else if (ALARM_ACK) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= 8'h00;
                out_q[i]    <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= commit;
            alarm_q <= alarm_d;
            if (state_q == RD_DATA && sample_en) begin
                shadow_q[idx_q] <= bcd_blank(AD_IN);
            end
            if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    out_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign SEGUNDO_T  = out_q[IDX_SEGUNDO];
    assign MINUTO_T   = out_q[IDX_MINUTO];
    assign HORA_T     = out_q[IDX_HORA];
    assign DIA_T      = out_q[IDX_DIA];
    assign MES_T      = out_q[IDX_MES];
    assign ANO_T      = out_q[IDX_ANO];
    assign SEGUNDOT_T = out_q[IDX_SEGUNDOT];
    assign MINUTOT_T  = out_q[IDX_MINUTOT];
    assign HORAT_T    = out_q[IDX_HORAT];

    assign ALARMA = alarm_q;
    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed and randomized sweeps against a bus-level RTC model and a snapshot reference.
module tb_rtc_bus_reader;

    localparam int unsigned TPH     = 8;
    localparam int unsigned TGAP    = 4;
    localparam int unsigned LATENCY = 20 * (TPH + TGAP) + 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       TIMER_EN = 1'b0;
    logic       ALARM_ACK = 1'b0;
    logic [7:0] AD_IN;
    logic [7:0] AD_OUT;
    logic       AD_OE, CS_N, AD_N, WR_N, RD_N;
    logic [7:0] DIA_T, MES_T, ANO_T, HORA_T, MINUTO_T, SEGUNDO_T;
    logic [7:0] HORAT_T, MINUTOT_T, SEGUNDOT_T;
    logic       ALARMA, BUSY, DONE;

    rtc_bus_reader #(
        .TPH  (TPH),
        .TGAP (TGAP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .TIMER_EN   (TIMER_EN),
        .ALARM_ACK  (ALARM_ACK),
        .AD_IN      (AD_IN),
        .AD_OUT     (AD_OUT),
        .AD_OE      (AD_OE),
        .CS_N       (CS_N),
        .AD_N       (AD_N),
        .WR_N       (WR_N),
        .RD_N       (RD_N),
        .DIA_T      (DIA_T),
        .MES_T      (MES_T),
        .ANO_T      (ANO_T),
        .HORA_T     (HORA_T),
        .MINUTO_T   (MINUTO_T),
        .SEGUNDO_T  (SEGUNDO_T),
        .HORAT_T    (HORAT_T),
        .MINUTOT_T  (MINUTOT_T),
        .SEGUNDOT_T (SEGUNDOT_T),
        .ALARMA     (ALARMA),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    // RTC bus model: latch address on AD_N, return register contents while RD_N is low.
    logic [7:0] mem [256];
    logic [7:0] addr_lat = 8'h00;
    always @(posedge CLK) if (!AD_N) addr_lat <= AD_OUT;
    assign AD_IN = !RD_N ? mem[addr_lat] : 8'hA5;

    // Protocol monitor: records each strobe-low run and each all-high gap.
    typedef struct {int kind; logic [7:0] val; int len;} ev_t;
    ev_t ev_q[$];
    int  gap_q[$];
    int  cur_kind = 0, run = 0, gap = 0, mon_k = 0;
    logic [7:0] cur_val = 8'h00;
    int  oe_rd_viol = 0;
    int  done_cnt = 0;

    always @(negedge CLK) begin
        if (AD_OE && !RD_N) oe_rd_viol++;
        if (DONE) done_cnt++;
        mon_k = !AD_N ? 1 : (!WR_N ? 2 : (!RD_N ? 3 : 0));
        if (mon_k != 0) begin
            if (gap > 0) begin gap_q.push_back(gap); gap = 0; end
            if (run > 0 && mon_k == cur_kind) begin
                run++;
            end else begin
                if (run > 0) ev_q.push_back('{cur_kind, cur_val, run});
                cur_kind = mon_k;
                cur_val  = (mon_k == 3) ? AD_IN : AD_OUT;
                run      = 1;
            end
        end else begin
            if (run > 0) begin ev_q.push_back('{cur_kind, cur_val, run}); run = 0; end
            if (!CS_N) gap++;
            else if (gap > 0) begin gap_q.push_back(gap); gap = 0; end
        end
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] addrs [9];
    logic [7:0] obs [9];
    logic       alarm_exp;
    int         lat, dc0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] clean(input logic [7:0] v);
        int hi, lo;
        hi = v / 16;
        lo = v % 16;
        if (hi > 9) hi = 15;
        if (lo > 9) lo = 15;
        return 8'(hi * 16 + lo);
    endfunction

    task automatic clear_mon();
        @(posedge CLK);
        ev_q.delete();
        gap_q.delete();
        run = 0;
        gap = 0;
    endtask

    task automatic sweep(input bit spam, output int l);
        clear_mon();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        l = 0;
        while (!DONE && l < 1000) begin
            START = spam && (l % 37 == 5);
            @(negedge CLK);
            l++;
        end
        START = 1'b0;
    endtask

    task automatic check_snapshot(input string tag);
        obs = '{SEGUNDO_T, MINUTO_T, HORA_T, DIA_T, MES_T, ANO_T,
                SEGUNDOT_T, MINUTOT_T, HORAT_T};
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_reg%02h", tag, addrs[i]), 32'(obs[i]), 32'(clean(mem[addrs[i]])));
        end
    endtask

    task automatic check_protocol(input string tag);
        chk({tag, "_nevents"}, 32'(ev_q.size()), 32'd20);
        chk({tag, "_ngaps"}, 32'(gap_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < ev_q.size(); i++) begin
            int ek;
            logic [7:0] evl;
            if (i == 0)      begin ek = 1; evl = 8'hF0; end
            else if (i == 1) begin ek = 2; evl = 8'hF0; end
            else if (i % 2 == 0) begin ek = 1; evl = addrs[(i - 2) / 2]; end
            else             begin ek = 3; evl = mem[addrs[(i - 2) / 2]]; end
            chk($sformatf("%s_ev%0d", tag, i),
                {ev_q[i].kind[7:0], ev_q[i].val, ev_q[i].len[15:0]},
                {ek[7:0], evl, 16'(TPH)});
        end
        for (int i = 0; i < gap_q.size(); i++) begin
            chk($sformatf("%s_gap%0d", tag, i), 32'(gap_q[i]), 32'(TGAP));
        end
        chk({tag, "_oe_rd"}, 32'(oe_rd_viol), 32'd0);
    endtask

    // Full sweep with latency, snapshot, alarm, protocol and single-DONE checks.
    task automatic full_sweep(input string tag, input bit spam);
        dc0 = done_cnt;
        sweep(spam, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        chk({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
        check_snapshot(tag);
        check_protocol(tag);
        chk({tag, "_alarm"}, 32'(ALARMA), 32'(alarm_exp));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        repeat (3) @(negedge CLK);
        chk({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    task automatic set_timer(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
        mem[8'h41] = s;
        mem[8'h42] = m;
        mem[8'h43] = h;
    endtask

    initial begin
        addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        alarm_exp = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_strobes", {28'd0, CS_N, AD_N, WR_N, RD_N}, 32'hF);
        chk("rst_ad_oe", 32'(AD_OE), 32'd0);
        chk("rst_ad_out", 32'(AD_OUT), 32'd0);
        chk("rst_dia", 32'(DIA_T), 32'd0);
        chk("rst_horat", 32'(HORAT_T), 32'd0);
        chk("rst_alarm", 32'(ALARMA), 32'd0);

        // Reference date/time, START pulses while busy must be ignored.
        mem[8'h24] = 8'h15; mem[8'h25] = 8'h07; mem[8'h26] = 8'h24;
        mem[8'h23] = 8'h09; mem[8'h22] = 8'h30; mem[8'h21] = 8'h45;
        set_timer(8'h12, 8'h34, 8'h56);
        TIMER_EN = 1'b0;
        full_sweep("ref", 1'b1);

        // Non-decimal nibble blanks to F.
        mem[8'h22] = 8'h3C;
        TIMER_EN = 1'b1;
        full_sweep("blank", 1'b1);
        chk("blank_minuto", 32'(MINUTO_T), 32'h3F);

        // Expired timer raises the alarm; acknowledge clears it.
        set_timer(8'h00, 8'h00, 8'h00);
        alarm_exp = 1'b1;
        full_sweep("alarm_set", 1'b0);
        @(negedge CLK); ALARM_ACK = 1'b1;
        @(negedge CLK); ALARM_ACK = 1'b0;
        chk("alarm_ack", 32'(ALARMA), 32'd0);
        alarm_exp = 1'b0;

        TIMER_EN = 1'b0;
        full_sweep("alarm_dis", 1'b0);

        // Set outranks a simultaneous acknowledge.
        TIMER_EN = 1'b1;
        ALARM_ACK = 1'b1;
        alarm_exp = 1'b1;
        dc0 = done_cnt;
        sweep(1'b0, lat);
        chk("setwin_latency", 32'(lat), 32'(LATENCY));
        chk("setwin_alarm", 32'(ALARMA), 32'd1);
        @(negedge CLK);
        chk("setwin_cleared", 32'(ALARMA), 32'd0);
        ALARM_ACK = 1'b0;
        alarm_exp = 1'b0;

        // Reset at cycle 100 aborts the sweep.
        set_timer(8'h01, 8'h02, 8'h03);
        clear_mon();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (99) @(negedge CLK);
        dc0 = done_cnt;
        RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        chk("abort_strobes", {28'd0, CS_N, AD_N, WR_N, RD_N}, 32'hF);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_segundo", 32'(SEGUNDO_T), 32'd0);
        chk("abort_ano", 32'(ANO_T), 32'd0);
        repeat (300) @(negedge CLK);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        full_sweep("after_abort", 1'b0);

        // Randomized register contents and timer enable.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 9; i++) mem[addrs[i]] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) set_timer(8'h00, 8'h00, 8'h00);
            TIMER_EN = 1'($urandom_range(0, 1));
            if (TIMER_EN && mem[8'h41] == 8'h00 && mem[8'h42] == 8'h00 && mem[8'h43] == 8'h00)
                alarm_exp = 1'b1;
            full_sweep($sformatf("rand%0d", n), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
